// File: rtl/booth_mult_arbiter_if.sv
// Requester, result and multiplier-side signals of booth_mult_arbiter.
// master is the arbiter's view; slave is the view of the clients, consumer and multiplier.
interface booth_mult_arbiter_if #(
    parameter int N = 4
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [4*N-1:0] mc_in;
    logic [4*N-1:0] mp_in;
    logic [N-1:0]   gnt;
    logic           res_valid;
    logic           res_ready;
    logic [IDW-1:0] res_id;
    logic [7:0]     res_prod;
    logic           res_err;
    logic           err;
    logic           mul_start;
    logic [3:0]     mul_mc;
    logic [3:0]     mul_mp;
    logic           mul_busy;
    logic [7:0]     mul_prod;

    modport master (
        input  req, mc_in, mp_in, res_ready, mul_busy, mul_prod,
        output gnt, res_valid, res_id, res_prod, res_err, err,
        output mul_start, mul_mc, mul_mp
    );

    modport slave (
        output req, mc_in, mp_in, res_ready, mul_busy, mul_prod,
        input  gnt, res_valid, res_id, res_prod, res_err, err,
        input  mul_start, mul_mc, mul_mp
    );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter that shares one sequential Booth multiplier between N requesters
// and returns each product, tagged with its requester id, over a valid/ready port.
module booth_mult_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    booth_mult_arbiter_if.master bus,
    output logic [2:0]           dbg_state
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam int WW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        DELIVER   = 3'd4
    } state_t;

    state_t         state_q, state_nx;
    logic [IDW-1:0] ptr_q, ptr_nx;
    logic [WW-1:0]  wcnt_q, wcnt_nx;
    logic [N-1:0]   gnt_q, gnt_nx;
    logic           start_q, start_nx;
    logic [3:0]     mc_q, mc_nx, mp_q, mp_nx;
    logic           valid_q, valid_nx;
    logic [IDW-1:0] id_q, id_nx;
    logic [7:0]     prod_q, prod_nx;
    logic           rerr_q, rerr_nx, err_q, err_nx;
    logic [IDW-1:0] pick_idx;
    logic           pick_found;
    int             j;

    // Scan downward so the last hit wins: that is the first set req after ptr.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        j          = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(ptr_q) + k) % N;
            if (bus.req[j]) begin
                pick_idx   = IDW'(j);
                pick_found = 1'b1;
            end
        end
    end

    // Result handshake: res_valid rises with id/prod/err already registered and all three
    // hold until a cycle with res_ready high; res_ready outside DELIVER has no effect.
    always_comb begin
        state_nx = state_q;
        ptr_nx   = ptr_q;
        wcnt_nx  = wcnt_q;
        mc_nx    = mc_q;
        mp_nx    = mp_q;
        id_nx    = id_q;
        prod_nx  = prod_q;
        rerr_nx  = rerr_q;
        err_nx   = err_q;
        gnt_nx   = '0;
        start_nx = 1'b0;
        valid_nx = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found && !bus.mul_busy) begin
                    state_nx         = LAUNCH;
                    ptr_nx           = pick_idx;
                    id_nx            = pick_idx;
                    mc_nx            = bus.mc_in[4*int'(pick_idx) +: 4];
                    mp_nx            = bus.mp_in[4*int'(pick_idx) +: 4];
                    gnt_nx[pick_idx] = 1'b1;
                    start_nx         = 1'b1;
                end
            end
            LAUNCH: begin
                state_nx = WAIT_BUSY;
                wcnt_nx  = '0;
            end
            WAIT_BUSY, WAIT_DONE: begin
                wcnt_nx = wcnt_q + WW'(1);
                if (state_q == WAIT_BUSY && bus.mul_busy) begin
                    state_nx = WAIT_DONE;
                end else if (state_q == WAIT_DONE && !bus.mul_busy) begin
                    state_nx = DELIVER;
                    prod_nx  = bus.mul_prod;
                    rerr_nx  = 1'b0;
                    valid_nx = 1'b1;
                end else if (wcnt_q >= WW'(TIMEOUT - 1)) begin
                    state_nx = DELIVER;
                    prod_nx  = 8'h00;
                    rerr_nx  = 1'b1;
                    err_nx   = 1'b1;
                    valid_nx = 1'b1;
                end
            end
            DELIVER: begin
                if (bus.res_ready) begin
                    state_nx = IDLE;
                end else begin
                    valid_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(N - 1);
            wcnt_q  <= '0;
            gnt_q   <= '0;
            start_q <= 1'b0;
            mc_q    <= 4'd0;
            mp_q    <= 4'd0;
            valid_q <= 1'b0;
            id_q    <= '0;
            prod_q  <= 8'h00;
            rerr_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nx;
            ptr_q   <= ptr_nx;
            wcnt_q  <= wcnt_nx;
            gnt_q   <= gnt_nx;
            start_q <= start_nx;
            mc_q    <= mc_nx;
            mp_q    <= mp_nx;
            valid_q <= valid_nx;
            id_q    <= id_nx;
            prod_q  <= prod_nx;
            rerr_q  <= rerr_nx;
            err_q   <= err_nx;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.mul_start = start_q;
    assign bus.mul_mc    = mc_q;
    assign bus.mul_mp    = mp_q;
    assign bus.res_valid = valid_q;
    assign bus.res_id    = id_q;
    assign bus.res_prod  = prod_q;
    assign bus.res_err   = rerr_q;
    assign bus.err       = err_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a behavioural multiplier (R=1, B adjustable).
module tb_booth_mult_arbiter;
    localparam int N = 4;
    localparam int TIMEOUT = 32;
    localparam int R = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] dbg_state;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    booth_mult_arbiter_if #(.N(N)) bus ();

    booth_mult_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Multiplier model: busy rises R cycles after mul_start falls, lasts m_b cycles, and the
    // product only appears when busy falls (0xA5 while busy exposes early capture).
    logic       m_busy  = 1'b0;
    logic [7:0] m_prod  = 8'h00;
    logic [7:0] m_res   = 8'h00;
    logic       m_stuck = 1'b0;
    int         m_b     = 5;
    int         r_left  = 0;
    int         b_left  = 0;

    assign bus.mul_busy = m_busy;
    assign bus.mul_prod = m_prod;

    function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
        logic signed [7:0] sa, sb, p;
        sa = $signed({{4{a[3]}}, a});
        sb = $signed({{4{b[3]}}, b});
        p  = sa * sb;
        return p;
    endfunction

    always @(posedge clk) begin
        if (bus.mul_start && !m_stuck) begin
            r_left <= R;
            m_res  <= smul(bus.mul_mc, bus.mul_mp);
        end else if (r_left > 0) begin
            r_left <= r_left - 1;
            if (r_left == 1) begin
                m_busy <= 1'b1;
                m_prod <= 8'hA5;
                b_left <= m_b;
            end
        end else if (b_left > 0) begin
            b_left <= b_left - 1;
            if (b_left == 1) begin
                m_busy <= 1'b0;
                m_prod <= m_res;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input string tag);
        int n;
        n = 0;
        while (bus.gnt == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_gnt_seen"}, 32'(bus.gnt != '0), 1);
    endtask

    // Call one cycle after the gnt sample; n counts cycles from gnt to res_valid.
    task automatic wait_valid(input string tag, output int n);
        n = 1;
        while (!bus.res_valid && n < 80) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid_seen"}, 32'(bus.res_valid), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 32'(bus.gnt), 0);
        check({tag, "_mul_start"}, 32'(bus.mul_start), 0);
        check({tag, "_mul_mc"}, 32'(bus.mul_mc), 0);
        check({tag, "_mul_mp"}, 32'(bus.mul_mp), 0);
        check({tag, "_res_valid"}, 32'(bus.res_valid), 0);
        check({tag, "_res_id"}, 32'(bus.res_id), 0);
        check({tag, "_res_prod"}, 32'(bus.res_prod), 0);
        check({tag, "_res_err"}, 32'(bus.res_err), 0);
        check({tag, "_err"}, 32'(bus.err), 0);
        check({tag, "_state"}, 32'(dbg_state), 0);
    endtask

    initial begin
        int         n;
        int         viol;
        int         busy_seen;
        logic [7:0] e;
        int         rr_id[5]   = '{0, 1, 2, 3, 0};
        logic [7:0] rr_prod[5] = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd2};

        rst_n         = 1'b0;
        bus.req       = '0;
        bus.mc_in     = '0;
        bus.mp_in     = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester 2: 3 * 5, latency R+B+2 = 8.
        bus.mc_in = {4'd0, 4'd3, 4'd0, 4'd0};
        bus.mp_in = {4'd0, 4'd5, 4'd0, 4'd0};
        bus.req   = 4'b0100;
        wait_gnt("t1");
        check("t1_gnt", 32'(bus.gnt), 32'b0100);
        check("t1_mul_start", 32'(bus.mul_start), 1);
        check("t1_mul_mc", 32'(bus.mul_mc), 3);
        check("t1_mul_mp", 32'(bus.mul_mp), 5);
        bus.req = '0;
        @(negedge clk);
        check("t1_gnt_pulse", 32'(bus.gnt), 0);
        check("t1_start_pulse", 32'(bus.mul_start), 0);
        wait_valid("t1", n);
        check("t1_latency", 32'(n), 8);
        check("t1_res_id", 32'(bus.res_id), 2);
        check("t1_res_prod", 32'(bus.res_prod), 15);
        check("t1_res_err", 32'(bus.res_err), 0);

        // Stall in DELIVER with other requests pending.
        bus.req = 4'b1011;
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (!(bus.res_valid === 1'b1 && bus.res_prod === 8'd15 && bus.res_id === 2'd2
                  && bus.gnt === 4'b0000 && bus.mul_mc === 4'd3 && bus.mul_mp === 4'd5))
                viol++;
        end
        check("t1_hold_stable", 32'(viol), 0);
        bus.req       = '0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("t1_released", 32'(bus.res_valid), 0);

        // Signed operands: -3 * 6 = -18 on requester 1.
        bus.mc_in = {4'd0, 4'd0, 4'b1101, 4'd0};
        bus.mp_in = {4'd0, 4'd0, 4'd6, 4'd0};
        bus.req   = 4'b0010;
        wait_gnt("t2");
        check("t2_gnt", 32'(bus.gnt), 32'b0010);
        bus.req = '0;
        @(negedge clk);
        wait_valid("t2", n);
        check("t2_res_prod", 32'(bus.res_prod), 32'hEE);
        check("t2_res_err", 32'(bus.res_err), 0);
        check("t2_res_id", 32'(bus.res_id), 1);
        @(negedge clk);

        // Round robin from a fresh reset with all requests held.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.mc_in = {4'd4, 4'd3, 4'd2, 4'd1};
        bus.mp_in = {4'd2, 4'd2, 4'd2, 4'd2};
        bus.req   = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_gnt("t3");
            check("t3_gnt_order", 32'(bus.gnt), 32'(1) << rr_id[i]);
            exp_q.push_back(rr_prod[i]);
            @(negedge clk);
            wait_valid("t3", n);
            if (i == 4) bus.req = '0;
            e = exp_q.pop_front();
            check("t3_res_id", 32'(bus.res_id), 32'(rr_id[i]));
            check("t3_res_prod", 32'(bus.res_prod), 32'(e));
        end
        @(negedge clk);
        @(negedge clk);

        // Stuck multiplier: timeout after 32 wait cycles.
        m_stuck   = 1'b1;
        bus.mc_in = {4'd7, 4'd0, 4'd0, 4'd0};
        bus.mp_in = {4'd7, 4'd0, 4'd0, 4'd0};
        bus.req   = 4'b1000;
        wait_gnt("t4");
        check("t4_gnt", 32'(bus.gnt), 32'b1000);
        bus.req = '0;
        @(negedge clk);
        wait_valid("t4", n);
        check("t4_latency", 32'(n), 33);
        check("t4_res_err", 32'(bus.res_err), 1);
        check("t4_res_prod", 32'(bus.res_prod), 0);
        check("t4_res_id", 32'(bus.res_id), 3);
        check("t4_err", 32'(bus.err), 1);
        @(negedge clk);
        m_stuck   = 1'b0;
        bus.mc_in = {4'd0, 4'd0, 4'd0, 4'd2};
        bus.mp_in = {4'd0, 4'd0, 4'd0, 4'd3};
        bus.req   = 4'b0001;
        wait_gnt("t4b");
        bus.req = '0;
        @(negedge clk);
        wait_valid("t4b", n);
        check("t4b_res_prod", 32'(bus.res_prod), 6);
        check("t4b_res_err", 32'(bus.res_err), 0);
        check("t4b_err_sticky", 32'(bus.err), 1);
        @(negedge clk);

        // Reset in WAIT_DONE while the multiplier stays busy; no grant until it goes idle.
        m_b       = 8;
        bus.mc_in = {4'd0, 4'd0, 4'd2, 4'd0};
        bus.mp_in = {4'd0, 4'd0, 4'd2, 4'd0};
        bus.req   = 4'b0010;
        wait_gnt("t5");
        n = 0;
        while (dbg_state != 3'd3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_in_wait_done", 32'(dbg_state), 3);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t5_rst");
        @(negedge clk);
        rst_n = 1'b1;
        m_b   = 5;
        viol      = 0;
        busy_seen = 0;
        n         = 0;
        while (bus.mul_busy && n < 40) begin
            if (bus.gnt !== 4'b0000) viol++;
            busy_seen++;
            @(negedge clk);
            n++;
        end
        check("t5_busy_after_release", 32'(busy_seen > 0), 1);
        check("t5_no_gnt_while_busy", 32'(viol), 0);
        wait_gnt("t5b");
        check("t5_gnt", 32'(bus.gnt), 32'b0010);
        bus.req = '0;
        @(negedge clk);
        wait_valid("t5", n);
        check("t5_res_prod", 32'(bus.res_prod), 4);
        check("t5_res_id", 32'(bus.res_id), 1);
        check("t5_res_err", 32'(bus.res_err), 0);
        check("t5_err", 32'(bus.err), 0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1, "watchdog");
    end
endmodule
